// File: rtl/sc_pkg.sv
// Shared types for the stochastic number generator: FSM state encoding and
// maximal-length LFSR tap masks for widths 4..16.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_e;

  // Masks are for a right-shifting register: tap n maps to bit (w - n), so
  // bit 0 (the oldest bit) is always a tap.
  function automatic logic [15:0] sc_tap_mask(input int w);
    case (w)
      4:       sc_tap_mask = 16'h0003;  // x^4+x^3+1
      5:       sc_tap_mask = 16'h0005;  // x^5+x^3+1
      6:       sc_tap_mask = 16'h0003;  // x^6+x^5+1
      7:       sc_tap_mask = 16'h0003;  // x^7+x^6+1
      8:       sc_tap_mask = 16'h001D;  // x^8+x^6+x^5+x^4+1
      9:       sc_tap_mask = 16'h0011;  // x^9+x^5+1
      10:      sc_tap_mask = 16'h0009;  // x^10+x^7+1
      11:      sc_tap_mask = 16'h0005;  // x^11+x^9+1
      12:      sc_tap_mask = 16'h0941;  // x^12+x^6+x^4+x+1
      13:      sc_tap_mask = 16'h1601;  // x^13+x^4+x^3+x+1
      14:      sc_tap_mask = 16'h2A01;  // x^14+x^5+x^3+x+1
      15:      sc_tap_mask = 16'h0003;  // x^15+x^14+1
      16:      sc_tap_mask = 16'h100B;  // x^16+x^15+x^13+x^4+1
      default: sc_tap_mask = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Right-shifting Fibonacci LFSR; with SC_SNG_ZERO_STATE_EN defined it becomes a
// de Bruijn counter that also visits the all-zero state (after 0..01).
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  localparam logic [15:0]      TAPS16 = sc_tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  logic [WIDTH-1:0] r_state;
  logic             w_fb;

  always_comb begin
    w_fb = ^(r_state & TAPS);
`ifdef SC_SNG_ZERO_STATE_EN
    // Toggling feedback when all bits but the outgoing one are zero splices
    // state 0 between 0..01 and 10..0 without touching the rest of the cycle.
    if (r_state[WIDTH-1:1] == '0) w_fb = ~w_fb;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SEED_V;
    end else if (load) begin
      r_state <= SEED_V;
    end else if (en) begin
      r_state <= {w_fb, r_state[WIDTH-1:1]};
    end
  end

  assign state = r_state;

endmodule

// File: rtl/sc_sng.sv
// Stochastic number generator: turns X into a unary stream with P(1)=X/2^WIDTH.
// Define SC_SNG_ZERO_STATE_EN for the 2^WIDTH-long exact-count variant.
module sc_sng
  import sc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  output logic             busy,
  output logic             sbit,
  output logic             svalid,
  output logic             done,
  output sc_state_e        dbg_state
);

  localparam int CW = WIDTH + 1;
`ifdef SC_SNG_ZERO_STATE_EN
  localparam logic [CW-1:0] LAST = CW'((1 << WIDTH) - 1);
`else
  localparam logic [CW-1:0] LAST = CW'((1 << WIDTH) - 2);
`endif

  if (WIDTH < 4 || WIDTH > 16) begin : g_width_chk
    $error("sc_sng: WIDTH must be in 4..16");
  end
  if (SEED <= 0 || SEED >= (1 << WIDTH)) begin : g_seed_chk
    $error("sc_sng: SEED must be nonzero and below 2^WIDTH");
  end

  // Handshake: start is a request accepted only on an IDLE edge (no queuing);
  // the stream then presents svalid=1 for L back-to-back cycles with sbit
  // valid alongside, followed by a single done cycle with svalid=0.
  sc_state_e        r_state;
  sc_state_e        w_next;
  logic [WIDTH-1:0] r_x;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_lfsr;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_x   <= X;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  sc_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (w_accept),
    .en    (r_state == RUN),
    .state (w_lfsr)
  );

  // Outputs decode registered state only, so they are glitch-free and zero
  // the cycle after any reset edge.
  assign busy      = (r_state != IDLE);
  assign svalid    = (r_state == RUN);
  assign sbit      = (r_state == RUN) && (w_lfsr < r_x);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sc_sng.sv
// Directed bench for sc_sng (WIDTH=8, SEED=1); expectations follow whether
// SC_SNG_ZERO_STATE_EN is defined for the build.
module tb_sc_sng;
  import sc_pkg::*;

  localparam int W = 8;
`ifdef SC_SNG_ZERO_STATE_EN
  localparam int L = 256;
`else
  localparam int L = 255;
`endif

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] X     = '0;
  logic         busy, sbit, svalid, done;
  sc_state_e    dbg_state;

  int           n_vec = 0;
  int           n_err = 0;
  logic [15:0]  exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sc_sng #(.WIDTH(W), .SEED(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .X         (X),
    .busy      (busy),
    .sbit      (sbit),
    .svalid    (svalid),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- model / checker ----------------
  function automatic int ones_model(input int x);
`ifdef SC_SNG_ZERO_STATE_EN
    return x;
`else
    return (x > 0) ? x - 1 : 0;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accepting edge; returns one step after done.
  task automatic measure(input int poke_cycle, input int poke_x,
                         output int ones, output int vlen, output int dpulses,
                         output int blen, output bit broken,
                         output bit b0, output bit b1);
    bit ended, seen_gap;
    int k;
    ones = 0; vlen = 0; dpulses = 0; blen = 0;
    broken = 0; b0 = 0; b1 = 0; ended = 0; seen_gap = 0; k = 0;
    while (!ended && k < 400) begin
      if (k == poke_cycle) begin
        start = 1'b1;
        X     = W'(poke_x);
      end else if (poke_cycle >= 0 && k == poke_cycle + 1) begin
        start = 1'b0;
      end
      if (svalid) begin
        if (vlen == 0) b0 = sbit;
        if (vlen == 1) b1 = sbit;
        if (seen_gap) broken = 1;
        vlen++;
        ones += int'(sbit);
      end else if (vlen > 0) begin
        seen_gap = 1;
      end
      if (busy) blen++;
      if (done) begin
        dpulses++;
        if (svalid || sbit) broken = 1;
        ended = 1;
      end
      step();
      k++;
    end
  endtask

  task automatic score(input string tag, input int ones, input int vlen,
                       input int dp, input int bl, input bit br);
    logic [15:0] e;
    e = exp_q.pop_front();
    check({tag, "_ones"}, ones, int'(e));
    check({tag, "_len"}, vlen, L);
    check({tag, "_done"}, dp, 1);
    check({tag, "_busy"}, bl, L + 1);
    check({tag, "_contig"}, int'(br), 0);
  endtask

  task automatic run_stream(input string tag, input int x,
                            output bit b0, output bit b1);
    int ones, vlen, dp, bl;
    bit br;
    X     = W'(x);
    start = 1'b1;
    exp_q.push_back(16'(ones_model(x)));
    step();
    start = 1'b0;
    check({tag, "_first_valid"}, int'(svalid), 1);
    measure(-1, 0, ones, vlen, dp, bl, br, b0, b1);
    score(tag, ones, vlen, dp, bl, br);
    check({tag, "_idle_after"}, int'(busy), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ones, vlen, dp, bl;
    bit br, b0, b1;

    // Reset with start held high: reset must win.
    rst = 1'b0; start = 1'b1; X = 8'd50;
    repeat (3) step();
    check("rst_busy", int'(busy), 0);
    check("rst_svalid", int'(svalid), 0);
    check("rst_sbit", int'(sbit), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    start = 1'b0;
    rst   = 1'b1;
    step();
    check("idle_state", int'(dbg_state), int'(IDLE));

    run_stream("x0", 0, b0, b1);
    run_stream("x128", 128, b0, b1);
    check("x128_bit0", int'(b0), 1);               // 1 < 128
    run_stream("x255", 255, b0, b1);
    run_stream("x1", 1, b0, b1);
    check("x1_bit0", int'(b0), 0);                 // 1 < 1 is false
`ifdef SC_SNG_ZERO_STATE_EN
    check("x1_bit1", int'(b1), 1);                 // zero state follows 0..01
`endif

    // start pulse and X change mid-run must not disturb the stream.
    X = 8'd200; start = 1'b1;
    exp_q.push_back(16'(ones_model(200)));
    step();
    start = 1'b0;
    measure(10, 7, ones, vlen, dp, bl, br, b0, b1);
    score("poke", ones, vlen, dp, bl, br);
    repeat (3) step();
    check("poke_no_requeue_busy", int'(busy), 0);
    check("poke_no_extra_done", int'(done), 0);

    // Reset at RUN cycle 50 aborts without done.
    X = 8'd100; start = 1'b1;
    step();
    start = 1'b0;
    repeat (49) step();
    check("abort_running", int'(svalid), 1);
    rst = 1'b0;
    step();
    check("abort_busy", int'(busy), 0);
    check("abort_svalid", int'(svalid), 0);
    check("abort_sbit", int'(sbit), 0);
    check("abort_done", int'(done), 0);
    rst = 1'b1;
    step();
    check("abort_idle_state", int'(dbg_state), int'(IDLE));
    check("abort_no_done", int'(done), 0);
    run_stream("post_rst", 77, b0, b1);

    // Back-to-back with start held high.
    X = 8'd60; start = 1'b1;
    exp_q.push_back(16'(ones_model(60)));
    step();
    measure(-1, 0, ones, vlen, dp, bl, br, b0, b1);
    score("b2b_a", ones, vlen, dp, bl, br);
    check("b2b_gap_busy", int'(busy), 0);
    X = 8'd90;
    exp_q.push_back(16'(ones_model(90)));
    step();
    start = 1'b0;
    check("b2b_restart", int'(svalid), 1);
    measure(-1, 0, ones, vlen, dp, bl, br, b0, b1);
    score("b2b_b", ones, vlen, dp, bl, br);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
